// File: rtl/nn_feature_buffer.sv
// Ping-pong staging buffer: assembles a serial nn_data_t stream into a
// FEATURES-wide vector for nn_Perceptron, one bank filling while the other drains.
package nn_pkg;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  typedef logic signed [DATA_W-1:0] nn_data_t;
endpackage

// One feature position across both banks.
module nn_fb_lane
  import nn_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we,
  input  logic     wbank,
  input  nn_data_t din,
  input  logic     rbank,
  output nn_data_t dout
);
  nn_data_t mem [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (we) begin
      mem[wbank] <= din;
    end
  end

  assign dout = mem[rbank];
endmodule

module nn_feature_buffer
  import nn_pkg::*;
#(
  parameter int FEATURES = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  nn_data_t                  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  output nn_data_t [FEATURES-1:0]   vec_o,
  output logic                      vec_v,
  input  logic                      vec_ready,
  output logic                      frame_err
);
  localparam int IW = (FEATURES > 2) ? $clog2(FEATURES) : 1;
  localparam logic [IW-1:0] LAST = IW'(FEATURES - 1);

  logic [1:0]          full;
  logic                wr_bank, rd_bank;
  logic [IW-1:0]       wr_idx;
  logic                acc, drain, at_last, short_f;
  logic [FEATURES-1:0] we;

  assign in_ready = !full[wr_bank];
  assign acc      = in_valid && in_ready;
  assign drain    = vec_v && vec_ready;
  assign at_last  = (wr_idx == LAST);
  // A short frame's terminating word is dropped along with the rest of it.
  assign short_f  = in_last && !at_last;
  assign vec_v    = full[rd_bank];

  genvar i;
  generate
    for (i = 0; i < FEATURES; i++) begin : g_lane
      assign we[i] = acc && !short_f && (wr_idx == IW'(i));
      nn_fb_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we[i]),
        .wbank (wr_bank),
        .din   (in_data),
        .rbank (rd_bank),
        .dout  (vec_o[i])
      );
    end
  endgenerate

  // Fill and drain never hit the same bank, so both full updates can coexist.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (acc) begin
        if (at_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_idx        <= '0;
          frame_err     <= !in_last;
        end else if (in_last) begin
          wr_idx    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
      if (drain) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_nn_feature_buffer.sv
// Bench for nn_feature_buffer: directed frame sequences then random traffic,
// all checked against a queue-of-frames reference model.
module tb_nn_feature_buffer;
  import nn_pkg::*;
  localparam int F = 11;
  typedef logic [15:0] w_t;
  typedef w_t frame_t [F];

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  nn_data_t             in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_last = 1'b0;
  nn_data_t [F-1:0]     vec_o;
  logic                 vec_v;
  logic                 vec_ready = 1'b0;
  logic                 frame_err;

  int n_cmp = 0;
  int n_err = 0;

  frame_t fq[$];
  w_t     part[$];
  logic   m_err = 1'b0;

  nn_feature_buffer #(.FEATURES(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .vec_o     (vec_o),
    .vec_v     (vec_v),
    .vec_ready (vec_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [F*16-1:0] got, input logic [F*16-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [F*16-1:0] pack(input frame_t f);
    logic [F*16-1:0] v;
    for (int i = 0; i < F; i++) v[i*16 +: 16] = f[i];
    return v;
  endfunction

  task automatic check_outputs();
    chk("in_ready", F*16'(in_ready), F*16'(fq.size() < 2));
    chk("vec_v", F*16'(vec_v), F*16'(fq.size() > 0));
    chk("frame_err", F*16'(frame_err), F*16'(m_err));
    if (fq.size() > 0) chk("vec_o", vec_o, pack(fq[0]));
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare.
  task automatic step(input logic v, input w_t d, input logic l, input logic r, output logic acc);
    frame_t f;
    logic   do_drain;
    in_valid = v; in_data = d; in_last = l; vec_ready = r;
    acc      = v && (fq.size() < 2);
    do_drain = r && (fq.size() > 0);
    @(posedge clk);
    m_err = 1'b0;
    if (do_drain) fq.delete(0);
    if (acc) begin
      part.push_back(d);
      if (part.size() == F) begin
        for (int i = 0; i < F; i++) f[i] = part[i];
        fq.push_back(f);
        part.delete();
        m_err = !l;
      end else if (l) begin
        part.delete();
        m_err = 1'b1;
      end
    end
    #1 check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; vec_ready = 1'b0;
    @(posedge clk);
    fq.delete(); part.delete(); m_err = 1'b0;
    #1 check_outputs();
    chk("rst_vec_o", vec_o, '0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int n, input w_t base, input logic last_at_end, input logic r);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, base + w_t'(i << 8), last_at_end && (i == n - 1), r, a);
  endtask

  initial begin
    logic a, v, l, r;
    w_t   d;
    do_reset();
    // Frame 1 fills bank 0, frame 2 fills bank 1, then both banks full.
    send_frame(F, 16'h0100, 1'b1, 1'b0);
    send_frame(F, 16'h1000, 1'b1, 1'b0);
    step(1'b1, 16'hdead, 1'b0, 1'b0, a);
    chk("held_word_rejected", F*16'(a), '0);
    step(1'b0, '0, 1'b0, 1'b1, a);
    step(1'b0, '0, 1'b0, 1'b0, a);
    // Short frame, then a clean frame.
    send_frame(5, 16'h2000, 1'b1, 1'b0);
    send_frame(F, 16'h3000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, a);
    step(1'b0, '0, 1'b0, 1'b1, a);
    // Long frame (no in_last).
    send_frame(F, 16'h4000, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, a);
    // Reset mid-frame with bank 0 full.
    send_frame(F, 16'h5000, 1'b1, 1'b0);
    send_frame(6, 16'h6000, 1'b0, 1'b0);
    do_reset();
    send_frame(F, 16'h7000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, a);
    // Back-to-back frames with the consumer always ready.
    for (int k = 0; k < 3; k++) send_frame(F, w_t'(16'h8000 + k * 16'h0010), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, a);
    // Random traffic; a rejected word is held until accepted.
    v = 1'b0; a = 1'b0; d = '0; l = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!v || a) begin
        v = ($urandom_range(0, 3) != 0);
        d = w_t'($urandom);
        l = ($urandom_range(0, 19) == 0) ||
            ((part.size() == F - 1) && ($urandom_range(0, 5) != 0));
      end
      r = ($urandom_range(0, 2) == 0);
      step(v, d, l, r, a);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
